semaforo_ctrl: RTL



---
 rtl/semaforo_ctrl_if.sv | 28 ++
 rtl/semaforo_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/semaforo_ctrl_if.sv
// Sensor inputs and lamp/status outputs of the two-way traffic-light sequencer.
// master = intersection side (drives sensors), slave = controller side.
interface semaforo_ctrl_if #(
  parameter int N_SENS = 2,
  parameter int CNT_W  = 8
);
  logic [N_SENS-1:0] ns_car;
  logic [N_SENS-1:0] lo_car;
  logic              night;
  logic              ns_green;
  logic              ns_yellow;
  logic              ns_red;
  logic              lo_green;
  logic              lo_yellow;
  logic              lo_red;
  logic [2:0]        phase;
  logic [CNT_W-1:0]  timer;

  modport master (
    output ns_car, lo_car, night,
    input  ns_green, ns_yellow, ns_red, lo_green, lo_yellow, lo_red, phase, timer
  );

  modport slave (
    input  ns_car, lo_car, night,
    output ns_green, ns_yellow, ns_red, lo_green, lo_yellow, lo_red, phase, timer
  );
endinterface

// File: rtl/semaforo_ctrl.sv
// Timed NS/LO traffic-light phase sequencer: green (min/max, demand-extended), yellow, all-red.
// Optional night flashing-yellow mode is compiled in with `define SEMAFORO_NIGHT_EN.
module semaforo_ctrl #(
  parameter int N_SENS       = 2,
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 40,
  parameter int YELLOW       = 4,
  parameter int ALL_RED      = 2,
  parameter int FLASH_PERIOD = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  semaforo_ctrl_if.slave bus
);
  localparam logic [2:0] AR_NS = 3'd0;
  localparam logic [2:0] NS_G  = 3'd1;
  localparam logic [2:0] NS_Y  = 3'd2;
  localparam logic [2:0] AR_LO = 3'd3;
  localparam logic [2:0] LO_G  = 3'd4;
  localparam logic [2:0] LO_Y  = 3'd5;

  localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_Y   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_SAT = {CNT_W{1'b1}};

  // Lamp vector order: {ns_green, ns_yellow, ns_red, lo_green, lo_yellow, lo_red}
  localparam logic [5:0] L_ALL_RED = 6'b001_001;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [5:0]       lamps_reg, lamps_next;
  logic             ns_dem, lo_dem;
  logic             flash_reg, flash_next;

  assign ns_dem = |bus.ns_car;
  assign lo_dem = |bus.lo_car;

`ifdef SEMAFORO_NIGHT_EN
  localparam logic [2:0]       FLASH = 3'd6;
  localparam logic [CNT_W-1:0] T_FL  = CNT_W'(FLASH_PERIOD - 1);
`else
  logic unused_night;
  assign unused_night = bus.night ^ FLASH_PERIOD[0];
`endif

  always_comb begin
    state_next = state_reg;
    timer_next = (timer_reg == T_SAT) ? timer_reg : timer_reg + 1'b1;
    flash_next = flash_reg;
    case (state_reg)
      AR_NS: if (timer_reg == T_AR) begin
        state_next = NS_G;
`ifdef SEMAFORO_NIGHT_EN
        if (bus.night) begin
          state_next = FLASH;
          flash_next = 1'b1;
        end
`endif
      end
      NS_G: if (timer_reg >= T_MIN && lo_dem && (!ns_dem || timer_reg == T_MAX))
        state_next = NS_Y;
      NS_Y: if (timer_reg == T_Y) state_next = AR_LO;
      AR_LO: if (timer_reg == T_AR) begin
        state_next = LO_G;
`ifdef SEMAFORO_NIGHT_EN
        if (bus.night) begin
          state_next = FLASH;
          flash_next = 1'b1;
        end
`endif
      end
      LO_G: if (timer_reg >= T_MIN && ns_dem && (!lo_dem || timer_reg == T_MAX))
        state_next = LO_Y;
      LO_Y: if (timer_reg == T_Y) state_next = AR_NS;
`ifdef SEMAFORO_NIGHT_EN
      FLASH: begin
        if (!bus.night) begin
          state_next = AR_NS;
        end else if (timer_reg == T_FL) begin
          flash_next = ~flash_reg;
          timer_next = '0;
        end
      end
`endif
      default: state_next = AR_NS;
    endcase

    // A resting green parks its timer at MAX_GREEN-1 so a late demand can max-out at once.
    if (state_next != state_reg)
      timer_next = '0;
    else if ((state_reg == NS_G || state_reg == LO_G) && timer_reg == T_MAX)
      timer_next = T_MAX;

    lamps_next = L_ALL_RED;
    case (state_next)
      NS_G:  lamps_next = 6'b100_001;
      NS_Y:  lamps_next = 6'b010_001;
      LO_G:  lamps_next = 6'b001_100;
      LO_Y:  lamps_next = 6'b001_010;
`ifdef SEMAFORO_NIGHT_EN
      FLASH: lamps_next = {1'b0, flash_next, 1'b0, 1'b0, flash_next, 1'b0};
`endif
      default: lamps_next = L_ALL_RED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= AR_NS;
      timer_reg <= '0;
      lamps_reg <= L_ALL_RED;
      flash_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      lamps_reg <= lamps_next;
      flash_reg <= flash_next;
    end
  end

  assign bus.phase     = state_reg;
  assign bus.timer     = timer_reg;
  assign bus.ns_green  = lamps_reg[5];
  assign bus.ns_yellow = lamps_reg[4];
  assign bus.ns_red    = lamps_reg[3];
  assign bus.lo_green  = lamps_reg[2];
  assign bus.lo_yellow = lamps_reg[1];
  assign bus.lo_red    = lamps_reg[0];
endmodule
